// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampled UART receiver with optional parity,
// one or two stop bits and a valid/ready output with error status.
module uart_rx_framed #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] par_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_RES  = CW'(M + 1);

    localparam logic [3:0] B_DLAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] B_SLAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                  r_sync1;
    logic                  r_sync2;
    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic [3:0]            r_bitn;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_perr_n;
    logic                  r_ferr_n;

    logic w_ds;
    logic w_res;
    logic w_wrap;
    logic w_bit;
    logic w_last_stop;
    logic w_deliver;

    assign w_ds   = r_sync2;
    assign w_res  = (r_cnt == C_RES);
    assign w_wrap = (r_cnt == C_LAST);
    assign w_bit  = (r_s0 & r_s1) | (r_s0 & w_ds) | (r_s1 & w_ds);

    assign w_last_stop = (r_state == S_STOP) && (r_bitn == B_SLAST);
    assign w_deliver   = w_last_stop && w_res;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Capture the first two of the three mid-bit majority samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_cnt == C_S0) r_s0 <= w_ds;
            if (r_cnt == C_S1) r_s1 <= w_ds;
        end
    end

    // Frame state machine: bit timing, shifting and error tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitn   <= '0;
            r_shift  <= '0;
            r_perr_n <= 1'b0;
            r_ferr_n <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_bitn <= '0;
                    if (!w_ds) begin
                        r_state  <= S_START;
                        r_perr_n <= 1'b0;
                        r_ferr_n <= 1'b0;
                    end
                end
                S_START: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_res && w_bit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state <= S_DATA;
                        r_bitn  <= '0;
                    end
                end
                S_DATA: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_res) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bitn == B_DLAST) begin
                            r_state <= PARITY_EN ? S_PARITY : S_STOP;
                            r_bitn  <= '0;
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_res) begin
                        r_perr_n <= ((^r_shift) ^ w_bit) != PARITY_ODD;
                    end
                    if (w_wrap) begin
                        r_state <= S_STOP;
                        r_bitn  <= '0;
                    end
                end
                S_STOP: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    if (w_res && !w_bit) r_ferr_n <= 1'b1;
                    if (w_deliver) begin
                        // Leave early so a following start edge is not missed.
                        r_state <= w_bit ? S_IDLE : S_BREAK;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_bitn <= r_bitn + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_ds) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output holding register with handshake and overrun detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_out    <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_deliver) begin
                par_out    <= r_shift;
                parity_err <= r_perr_n;
                frame_err  <= r_ferr_n | ~w_bit;
                out_valid  <= 1'b1;
                overrun    <= out_valid & ~out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed table, corner sequences and random
// frames checked against a frame-level model for three configurations.
module tb_uart_rx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] din_v;
    logic [2:0] rdy;
    logic [7:0] po0;
    logic [7:0] po1;
    logic [6:0] po2;
    logic [2:0] ov;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] ovr;

    uart_rx_framed u0 (
        .clk(clk), .reset(rst_n), .din(din_v[0]), .par_out(po0),
        .out_valid(ov[0]), .out_ready(rdy[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun(ovr[0])
    );

    uart_rx_framed #(.PARITY_EN(1'b1)) u1 (
        .clk(clk), .reset(rst_n), .din(din_v[1]), .par_out(po1),
        .out_valid(ov[1]), .out_ready(rdy[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun(ovr[1])
    );

    uart_rx_framed #(.DATA_WIDTH(7), .OVERSAMPLE(8), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(rst_n), .din(din_v[2]), .par_out(po2),
        .out_valid(ov[2]), .out_ready(rdy[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .overrun(ovr[2])
    );

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stp;
        logic [8:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];

    int cyc = 0;
    int ovr_cnt[3] = '{default: 0};
    int rise_cyc[3] = '{default: 0};
    int rises[3] = '{default: 0};
    int width[3] = '{default: 0};
    int wcur[3] = '{default: 0};
    logic [2:0] pv = 3'b000;

    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level monitor: accepted frames, pulse widths, overruns.
    always @(negedge clk) begin
        if (ov[0] && rdy[0]) q0.push_back('{d: {1'b0, po0}, pe: pe[0], fe: fe[0]});
        if (ov[1] && rdy[1]) q1.push_back('{d: {1'b0, po1}, pe: pe[1], fe: fe[1]});
        if (ov[2] && rdy[2]) q2.push_back('{d: {2'b0, po2}, pe: pe[2], fe: fe[2]});
        for (int i = 0; i < 3; i++) begin
            if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
            if (ov[i]) begin
                wcur[i] <= wcur[i] + 1;
            end else if (wcur[i] != 0) begin
                width[i] <= wcur[i];
                wcur[i]  <= 0;
            end
            if (ov[i] && !pv[i]) begin
                rise_cyc[i] <= cyc;
                rises[i]    <= rises[i] + 1;
            end
        end
        pv <= ov;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: no finish within 3 ms");
        $fatal(1);
    end

    function automatic int os_of(input int d);
        return (d == 2) ? 8 : 16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic drive(input int d, input logic b, input int n);
        din_v[d] = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int d, input int nbits);
        drive(d, 1'b1, os_of(d) * nbits);
    endtask

    task automatic send(input int d, input logic [8:0] data,
                        input logic pbit, input logic [1:0] stp);
        int nb;
        int ns;
        int os;
        bit pen;
        os  = os_of(d);
        nb  = (d == 2) ? 7 : 8;
        ns  = (d == 2) ? 2 : 1;
        pen = (d == 1);
        drive(d, 1'b0, os);
        for (int i = 0; i < nb; i++) drive(d, data[i], os);
        if (pen) drive(d, pbit, os);
        for (int i = 0; i < ns; i++) drive(d, stp[i], os);
        din_v[d] = 1'b1;
    endtask

    task automatic pop(input int d, output rec_t r, output bit ok);
        ok = 1'b0;
        r  = '{d: '0, pe: 1'b0, fe: 1'b0};
        for (int k = 0; k < 60 && !ok; k++) begin
            if (d == 0 && q0.size() > 0) begin
                r = q0.pop_front(); ok = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
                r = q1.pop_front(); ok = 1'b1;
            end else if (d == 2 && q2.size() > 0) begin
                r = q2.pop_front(); ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic expect_frame(input string nm, input int d,
                                input logic [8:0] ed, input logic epe,
                                input logic efe);
        rec_t r;
        bit ok;
        pop(d, r, ok);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: no frame delivered, want data 0x%0h", nm, ed);
        end else begin
            chk({nm, " data"}, 32'(r.d), 32'(ed));
            chk({nm, " perr"}, 32'(r.pe), 32'(epe));
            chk({nm, " ferr"}, 32'(r.fe), 32'(efe));
        end
    endtask

    vec_t tv[9];
    int   s0;
    int   r0;
    int   o0;

    initial begin
        tv[0] = '{0, 9'h00, 1'b0, 2'b11, 9'h00, 1'b0, 1'b0};
        tv[1] = '{0, 9'hFF, 1'b0, 2'b11, 9'hFF, 1'b0, 1'b0};
        tv[2] = '{0, 9'hC4, 1'b0, 2'b10, 9'hC4, 1'b0, 1'b1};
        tv[3] = '{1, 9'h07, 1'b1, 2'b11, 9'h07, 1'b0, 1'b0};
        tv[4] = '{1, 9'h07, 1'b0, 2'b11, 9'h07, 1'b1, 1'b0};
        tv[5] = '{1, 9'hA5, 1'b1, 2'b11, 9'hA5, 1'b1, 1'b0};
        tv[6] = '{2, 9'h5A, 1'b0, 2'b11, 9'h5A, 1'b0, 1'b0};
        tv[7] = '{2, 9'h33, 1'b0, 2'b01, 9'h33, 1'b0, 1'b1};
        tv[8] = '{2, 9'h7F, 1'b0, 2'b10, 9'h7F, 1'b0, 1'b1};

        din_v = 3'b111;
        rdy   = 3'b111;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst po0", 32'(po0), 0);
        chk("rst po2", 32'(po2), 0);
        chk("rst ov", 32'(ov), 0);
        chk("rst pe", 32'(pe), 0);
        chk("rst fe", 32'(fe), 0);
        chk("rst ovr", 32'(ovr), 0);
        rst_n = 1'b1;
        idle(0, 2);

        s0 = cyc;
        send(0, 9'h55, 1'b0, 2'b11);
        expect_frame("t1 0x55", 0, 9'h55, 1'b0, 1'b0);
        chk_rng("t1 latency", rise_cyc[0] - s0, 9 * 16 + 8, 10 * 16 - 1);
        idle(0, 1);
        chk("t1 pulse width", 32'(width[0]), 1);

        r0 = rises[0];
        drive(0, 1'b0, 4);
        idle(0, 3);
        chk("t2 glitch no frame", 32'(rises[0] - r0), 0);
        send(0, 9'hA3, 1'b0, 2'b11);
        expect_frame("t2 0xA3", 0, 9'hA3, 1'b0, 1'b0);
        idle(0, 2);

        for (int i = 0; i < 9; i++) begin
            send(tv[i].dut, tv[i].data, tv[i].pbit, tv[i].stp);
            expect_frame($sformatf("vec%0d", i), tv[i].dut,
                         tv[i].ed, tv[i].epe, tv[i].efe);
            idle(tv[i].dut, 2);
        end

        send(0, 9'h81, 1'b0, 2'b10);
        din_v[0] = 1'b0;
        expect_frame("t4 break", 0, 9'h81, 1'b0, 1'b1);
        r0 = rises[0];
        drive(0, 1'b0, 16 * 20);
        chk("t4 no frame while low", 32'(rises[0] - r0), 0);
        idle(0, 2);
        send(0, 9'h3C, 1'b0, 2'b11);
        expect_frame("t4 0x3C", 0, 9'h3C, 1'b0, 1'b0);
        idle(0, 2);

        rdy[0] = 1'b0;
        o0 = ovr_cnt[0];
        send(0, 9'h11, 1'b0, 2'b11);
        chk("t5 first no overrun", 32'(ovr_cnt[0] - o0), 0);
        send(0, 9'h22, 1'b0, 2'b11);
        idle(0, 1);
        chk("t5 overrun one clk", 32'(ovr_cnt[0] - o0), 1);
        chk("t5 par_out", 32'(po0), 32'h22);
        chk("t5 valid held", 32'(ov[0]), 1);
        #1 rdy[0] = 1'b1;
        @(negedge clk);
        chk("t5 valid drop", 32'(ov[0]), 0);
        idle(0, 1);

        rdy[0] = 1'b0;
        send(0, 9'h99, 1'b0, 2'b11);
        idle(0, 1);
        chk("t6 held before reset", 32'(ov[0]), 1);
        fork
            send(0, 9'hC3, 1'b0, 2'b11);
            begin
                repeat (16 * 5 + 8) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("t6 rst po0", 32'(po0), 0);
                chk("t6 rst ov", 32'(ov[0]), 0);
            end
        join
        rst_n  = 1'b1;
        rdy[0] = 1'b1;
        r0 = rises[0];
        idle(0, 3);
        chk("t6 partial discarded", 32'(rises[0] - r0), 0);
        send(0, 9'h5A, 1'b0, 2'b11);
        expect_frame("t6 0x5A", 0, 9'h5A, 1'b0, 1'b0);
        idle(0, 2);

        fork
            send(2, 9'h2D, 1'b0, 2'b11);
            begin
                repeat (8 * 5 + 4) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("t6b rst po2", 32'(po2), 0);
            end
        join
        rst_n = 1'b1;
        idle(2, 3);
        send(2, 9'h5A, 1'b0, 2'b11);
        expect_frame("t6b 0x5A", 2, 9'h5A, 1'b0, 1'b0);
        idle(2, 2);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 15; n++) begin
                logic [8:0] data;
                logic       pbit;
                logic [1:0] stp;
                logic       epe;
                logic       efe;
                int         ns;
                ns   = (d == 2) ? 2 : 1;
                data = 9'($urandom) & ((d == 2) ? 9'h07F : 9'h0FF);
                pbit = 1'($urandom);
                stp[0] = ($urandom_range(0, 4) != 0);
                stp[1] = ($urandom_range(0, 4) != 0);
                epe = (d == 1) && ((($countones(data) + int'(pbit)) % 2) == 1);
                efe = (ns == 2) ? !(stp[0] && stp[1]) : !stp[0];
                send(d, data, pbit, stp);
                expect_frame($sformatf("rnd d%0d n%0d", d, n), d,
                             data, epe, efe);
                if (efe) idle(d, 1);
                else idle(d, $urandom_range(0, 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
